hazard_scoreboard: RTL and testbench



---
 rtl/pipeline_pkg.sv | 10 +
 rtl/hazard_scoreboard_if.sv | 31 +++
 rtl/hazard_scoreboard_counter.sv | 29 ++
 rtl/hazard_scoreboard.sv | 80 ++++++++
 tb/tb_hazard_scoreboard.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-file geometry and in-flight write
// limits used by the hazard scoreboard and its per-register counters.
package pipeline_pkg;
  localparam int REG_INDEX_WIDTH = 5;
  localparam int NUM_REGS        = 32;
  localparam int MAX_INFLIGHT    = 2;
  localparam int COUNT_WIDTH     = $clog2(MAX_INFLIGHT + 1);

  typedef logic [REG_INDEX_WIDTH-1:0] reg_index_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/EX/WB control bundle between the pipeline and the hazard scoreboard.
//   master : pipeline side, drives ID operands, EX flush and WB retire; sees id_stall
//   slave  : scoreboard side
interface hazard_scoreboard_if;
  import pipeline_pkg::*;

  logic       id_valid;
  reg_index_t id_rs1_index;
  logic       id_rs1_used;
  reg_index_t id_rs2_index;
  logic       id_rs2_used;
  reg_index_t id_rd_index;
  logic       id_writes_rd;
  logic       ex_flush;
  logic       wb_valid;
  reg_index_t wb_rd_index;
  logic       wb_writes_rd;
  logic       id_stall;

  modport master (
    output id_valid, id_rs1_index, id_rs1_used, id_rs2_index, id_rs2_used,
           id_rd_index, id_writes_rd, ex_flush, wb_valid, wb_rd_index, wb_writes_rd,
    input  id_stall
  );

  modport slave (
    input  id_valid, id_rs1_index, id_rs1_used, id_rs2_index, id_rs2_used,
           id_rd_index, id_writes_rd, ex_flush, wb_valid, wb_rd_index, wb_writes_rd,
    output id_stall
  );
endinterface

// File: rtl/hazard_scoreboard_counter.sv
// reg_pending_counter: outstanding-write count for one architectural register.
//   inc/dec : issue / retire targeting this register
//   count   : writes in flight; nonzero/full decoded from it
//   err     : this cycle's update would under/overflow (counter holds instead)
module reg_pending_counter #(
  parameter int MAX_INFLIGHT = pipeline_pkg::MAX_INFLIGHT,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          nonzero,
  output logic          full,
  output logic          err
);
  assign nonzero = (count != '0);
  assign full    = (count == CW'(MAX_INFLIGHT));

  // Simultaneous inc+dec nets to zero change, so it is never an error.
  assign err = (inc & ~dec & full) | (dec & ~inc & ~nonzero);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      count <= '0;
    else if (inc && !dec && !full)     count <= count + 1'b1;
    else if (dec && !inc && nonzero)   count <= count - 1'b1;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks registers with writes in flight between issue
// (ID->EX) and retire (WB) and stalls decode on RAW / full-WAW hazards.
//   clk, reset_n   : clock, async active-low reset
//   sb             : ID operands, EX flush, WB retire in; id_stall out (comb)
//   pending_mask   : bit n set while register n has writes in flight (registered)
//   overflow_error : sticky counter under/overflow flag
//   stall_cycles   : saturating count of stalled cycles
module hazard_scoreboard #(
  parameter int NUM_REGS     = pipeline_pkg::NUM_REGS,
  parameter int MAX_INFLIGHT = pipeline_pkg::MAX_INFLIGHT
) (
  input  logic                clk,
  input  logic                reset_n,
  hazard_scoreboard_if.slave  sb,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                overflow_error,
  output logic [31:0]         stall_cycles
);
  import pipeline_pkg::*;

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [NUM_REGS-1:0]         inc_oh, dec_oh, nz, full, err;
  logic [NUM_REGS-1:0][CW-1:0] cnt;
  logic                        issue, retire, raw, waw;

  // Hazards use registered counts only; a same-cycle retire does not bypass.
  assign raw = (sb.id_rs1_used & nz[sb.id_rs1_index]) |
               (sb.id_rs2_used & nz[sb.id_rs2_index]);
  assign waw = sb.id_writes_rd & (sb.id_rd_index != '0) & full[sb.id_rd_index];

  // A flushed ID instruction is discarded, so there is nothing to hold.
  assign sb.id_stall = sb.id_valid & (raw | waw) & ~sb.ex_flush;

  assign issue  = sb.id_valid & ~sb.id_stall & ~sb.ex_flush &
                  sb.id_writes_rd & (sb.id_rd_index != '0);
  assign retire = sb.wb_valid & sb.wb_writes_rd & (sb.wb_rd_index != '0);

  always_comb begin
    inc_oh = '0;
    dec_oh = '0;
    if (issue)  inc_oh[sb.id_rd_index] = 1'b1;
    if (retire) dec_oh[sb.wb_rd_index] = 1'b1;
  end

  // x0 is hardwired zero and never tracked.
  assign cnt[0]  = '0;
  assign nz[0]   = 1'b0;
  assign full[0] = 1'b0;
  assign err[0]  = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    reg_pending_counter #(.MAX_INFLIGHT(MAX_INFLIGHT), .CW(CW)) u_cnt (
      .clk    (clk),
      .reset_n(reset_n),
      .inc    (inc_oh[g]),
      .dec    (dec_oh[g]),
      .count  (cnt[g]),
      .nonzero(nz[g]),
      .full   (full[g]),
      .err    (err[g])
    );
  end

  // Counts are flops, so this decode tracks them edge-for-edge.
  always_comb begin
    pending_mask = '0;
    for (int n = 0; n < NUM_REGS; n++) pending_mask[n] = (cnt[n] != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_error <= 1'b0;
      stall_cycles   <= '0;
    end else begin
      if (|err) overflow_error <= 1'b1;
      if (sb.id_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pending_mask;
  logic        overflow_error;
  logic [31:0] stall_cycles;
  int          ncmp = 0;
  int          nfail = 0;

  hazard_scoreboard_if hif();

  hazard_scoreboard dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sb            (hif.slave),
    .pending_mask  (pending_mask),
    .overflow_error(overflow_error),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       idv;
    logic [4:0] rs1; logic rs1u;
    logic [4:0] rs2; logic rs2u;
    logic [4:0] rd;  logic wrd;
    logic       fl;
    logic       wbv; logic [4:0] wbrd; logic wbw;
    logic        e_stall;
    logic [31:0] e_mask;
    logic        e_err;
    logic [31:0] e_cyc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic idv, logic [4:0] rs1, logic rs1u, logic [4:0] rs2,
                              logic rs2u, logic [4:0] rd, logic wrd, logic fl,
                              logic wbv, logic [4:0] wbrd, logic wbw,
                              logic es, logic [31:0] em, logic ee, logic [31:0] ec);
    vec_t v;
    v.idv = idv; v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u;
    v.rd = rd; v.wrd = wrd; v.fl = fl; v.wbv = wbv; v.wbrd = wbrd; v.wbw = wbw;
    v.e_stall = es; v.e_mask = em; v.e_err = ee; v.e_cyc = ec;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic idv, logic [4:0] rs1, logic rs1u, logic [4:0] rs2, logic rs2u,
                       logic [4:0] rd, logic wrd, logic fl,
                       logic wbv, logic [4:0] wbrd, logic wbw);
    hif.id_valid = idv; hif.id_rs1_index = rs1; hif.id_rs1_used = rs1u;
    hif.id_rs2_index = rs2; hif.id_rs2_used = rs2u;
    hif.id_rd_index = rd; hif.id_writes_rd = wrd; hif.ex_flush = fl;
    hif.wb_valid = wbv; hif.wb_rd_index = wbrd; hif.wb_writes_rd = wbw;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  localparam logic [31:0] B5 = 32'h1 << 5, B6 = 32'h1 << 6, B7 = 32'h1 << 7, B9 = 32'h1 << 9;

  initial begin
    int stalls;
    bit done;
    idle();

    //        idv rs1 u  rs2 u  rd wr fl wbv wrd wbw stall mask     err cyc
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,       0, 0)); // idle
    vt.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,  0, B5,      0, 0)); // issue x5
    vt.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0,  1, B5,      0, 1)); // RAW stall
    vt.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 1, 5, 1,  1, 0,       0, 2)); // retire, no bypass
    vt.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0,  0, B6,      0, 2)); // consumer issues
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1,  0, 0,       0, 2)); // retire x6
    vt.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0,  0, 0,       0, 2)); // x0 write/read
    vt.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  0, B7,      0, 2)); // x7 cnt 1
    vt.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 7, 1,  0, B7,      0, 2)); // issue+retire x7
    vt.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  0, B7,      0, 2)); // x7 cnt 2 (full)
    vt.push_back(mk(0, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0,  0, B7,      0, 2)); // not valid
    vt.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  1, B7,      0, 3)); // WAW full stall
    vt.push_back(mk(1, 0, 0, 7, 1, 9, 1, 1, 0, 0, 0,  0, B7,      0, 3)); // flush wins
    vt.push_back(mk(1, 0, 1, 7, 0, 9, 1, 0, 0, 0, 0,  0, B7 | B9, 0, 3)); // rs2 unused
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1,  0, B7 | B9, 0, 3)); // x7 -> 1
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1,  0, B9,      0, 3)); // x7 -> 0
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1,  0, 0,       0, 3)); // x9 -> 0
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1,  0, 0,       1, 3)); // underflow
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, 0,       1, 3)); // sticky, ignored wb
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1,  0, 0,       1, 3)); // wb_valid low

    // Reset state, with a would-be hazard presented on the inputs.
    drive(1, 5, 1, 5, 1, 5, 1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(hif.id_stall), 0);
    chk("rst_mask", pending_mask, 0);
    chk("rst_err", 32'(overflow_error), 0);
    chk("rst_cyc", stall_cycles, 0);
    @(negedge clk);
    idle();
    reset_n = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].idv, vt[i].rs1, vt[i].rs1u, vt[i].rs2, vt[i].rs2u, vt[i].rd, vt[i].wrd,
            vt[i].fl, vt[i].wbv, vt[i].wbrd, vt[i].wbw);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(hif.id_stall), 32'(vt[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_mask", i), pending_mask, vt[i].e_mask);
      chk($sformatf("v%0d_err", i), 32'(overflow_error), 32'(vt[i].e_err));
      chk($sformatf("v%0d_cyc", i), stall_cycles, vt[i].e_cyc);
    end

    // Reset clears the sticky error and counters asynchronously.
    @(negedge clk);
    idle();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_err", 32'(overflow_error), 0);
    chk("arst_cyc", stall_cycles, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Dependent pair: producer x10 issues, consumer reads x10 and writes x11.
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0);
    @(posedge clk);
    stalls = 0;
    done = 0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      drive(1, 10, 1, 0, 0, 11, 1, 0, (c == 1), 10, 1); // producer in WB on 2nd cycle
      #1;
      if (hif.id_stall) stalls++;
      else done = 1;
      @(posedge clk);
    end
    #1;
    if (!done) begin
      ncmp++; nfail++;
      $display("FAIL pair_timeout: consumer still stalled after 8 cycles");
    end
    chk("pair_stalls", stalls, 2);
    chk("pair_cyc", stall_cycles, 2);
    chk("pair_mask", pending_mask, 32'h1 << 11);

    // Mid-operation reset forgets x4; its later retire flags an error.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 4, 1, 0, 1, 11, 1);
    @(posedge clk);
    #1;
    chk("mid_mask_pre", pending_mask, 32'h1 << 4);
    @(negedge clk);
    idle();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_mask_rst", pending_mask, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1);
    @(posedge clk);
    #1;
    chk("mid_err", 32'(overflow_error), 1);
    chk("mid_mask_post", pending_mask, 0);
    @(negedge clk);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
